gray2bin_rr_arbiter: RTL

- Shares one Gray-to-binary conversion datapath among NREQ requesters using round-robin arbitration.
- Each requester presents a Gray-coded word with a request. The arbiter grants one requester, registers its word, and converts it (MSB kept, each lower bit XORed with the next-higher binary bit).
- The binary result and requester ID are presented on a valid/ready output port.
- Sits between multiple Gray-coded sources (e.g. position encoders, async-FIFO pointers) and a single binary consumer.

---
 rtl/gray2bin_rr_arbiter_if.sv | 27 ++
 rtl/gray2bin_rr_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/gray2bin_rr_arbiter_if.sv
// Request/grant and result handshake bundle for the shared Gray-to-binary converter.
interface gray2bin_rr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] gray_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      bin_out;
  logic [IDW-1:0]        out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  // Requesters and consumer side.
  modport master (
    output req, gray_in, out_ready,
    input  gnt, bin_out, out_id, out_valid, busy
  );

  // Arbiter/converter side.
  modport slave (
    input  req, gray_in, out_ready,
    output gnt, bin_out, out_id, out_valid, busy
  );
endinterface

// File: rtl/gray2bin_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered Gray-to-binary converter among NREQ
// requesters. One word in flight at a time: IDLE -> CONV -> HOLD -> IDLE.
module gray2bin_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input logic                clk,
  input logic                rst,
  gray2bin_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

  localparam logic [IDW:0]   NReqW  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   out_id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             out_valid_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] win_gray;
  logic [IDW-1:0]   next_ptr;

  // B[msb] = G[msb]; each lower bit XORs in the binary bit above it.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Search rr_ptr, rr_ptr+1, ... (mod NREQ); first active request wins.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= NReqW) begin
        sum = sum - NReqW;
      end
      cand = sum[IDW-1:0];
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pick the winner's word out of the packed Gray bus.
  always_comb begin
    win_gray = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_idx) begin
        win_gray = bus.gray_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves just past the requester that was served, so it ends up last in line.
  always_comb begin
    next_ptr = (id_q == LastId) ? '0 : id_q + 1'b1;
  end

  // Control FSM with all outputs registered; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gray_q      <= '0;
      id_q        <= '0;
      bin_q       <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            gray_q  <= win_gray;
            id_q    <= win_idx;
            gnt_q   <= NREQ'(1) << win_idx;
            state_q <= StConv;
          end else begin
            gnt_q <= '0;
          end
        end
        StConv: begin
          gnt_q       <= '0;
          bin_q       <= g2b(gray_q);
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= next_ptr;
            state_q     <= StIdle;
          end
        end
        default: begin
          gnt_q       <= '0;
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bin_out   = bin_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
